// File: rtl/jpeg_unstuff.sv
// JPEG entropy-stream unstuffer: drops stuffed 0x00 and fill 0xFF bytes, detects
// markers, and repacks data bytes MSB-first into 16-bit words.
module jpeg_unstuff #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_byte,
   input  logic             ena_in,
   output logic             rdy_out,
   output logic [15:0]      out_bits,
   output logic             ena_out,
   input  logic             rdy_in,
   output logic             out_padded,
   output logic [7:0]       marker,
   output logic             marker_valid,
   input  logic             marker_ack,
   output logic [CNT_W-1:0] stuff_count
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam logic [BYTE_W-1:0] FF_BYTE    = 8'hFF;
   localparam logic [BYTE_W-1:0] STUFF_BYTE = 8'h00;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      SAW_FF = 2'd1,
      MARKER = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [BYTE_W-1:0]   hi_byte, hi_byte_d;
   logic                half_valid, half_valid_d;
   logic [WORD_W-1:0]   out_bits_d;
   logic                ena_out_d;
   logic                out_padded_d;
   logic [BYTE_W-1:0]   marker_d;
   logic                marker_valid_d;
   logic [CNT_W-1:0]    stuff_count_d;
   logic                accept;
   logic                app;
   logic [BYTE_W-1:0]   app_data;
   logic                flush;

   // A full output word with a pending half byte can only move on if the word drains.
   assign rdy_out = (state != MARKER) && (!half_valid || !ena_out || rdy_in);
   assign accept  = ena_in && rdy_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= NORMAL;
         hi_byte      <= '0;
         half_valid   <= 1'b0;
         out_bits     <= '0;
         ena_out      <= 1'b0;
         out_padded   <= 1'b0;
         marker       <= '0;
         marker_valid <= 1'b0;
         stuff_count  <= '0;
      end else begin
         state        <= state_d;
         hi_byte      <= hi_byte_d;
         half_valid   <= half_valid_d;
         out_bits     <= out_bits_d;
         ena_out      <= ena_out_d;
         out_padded   <= out_padded_d;
         marker       <= marker_d;
         marker_valid <= marker_valid_d;
         stuff_count  <= stuff_count_d;
      end
   end

   always_comb begin
      state_d        = state;
      hi_byte_d      = hi_byte;
      half_valid_d   = half_valid;
      out_bits_d     = out_bits;
      ena_out_d      = ena_out;
      out_padded_d   = out_padded;
      marker_d       = marker;
      marker_valid_d = marker_valid;
      stuff_count_d  = stuff_count;
      app            = 1'b0;
      app_data       = in_byte;
      flush          = 1'b0;

      if (ena_out && rdy_in) begin
         ena_out_d    = 1'b0;
         out_bits_d   = '0;
         out_padded_d = 1'b0;
      end

      case (state)
         NORMAL: begin
            if (accept) begin
               if (in_byte == FF_BYTE) state_d = SAW_FF;
               else                    app     = 1'b1;
            end
         end
         SAW_FF: begin
            if (accept) begin
               if (in_byte == STUFF_BYTE) begin
                  app      = 1'b1;
                  app_data = FF_BYTE;
                  if (stuff_count != {CNT_W{1'b1}})
                     stuff_count_d = stuff_count + CNT_W'(1);
                  state_d  = NORMAL;
               end else if (in_byte != FF_BYTE) begin
                  marker_d       = in_byte;
                  marker_valid_d = 1'b1;
                  flush          = 1'b1;
                  state_d        = MARKER;
               end
            end
         end
         MARKER: begin
            if (marker_ack) begin
               marker_valid_d = 1'b0;
               state_d        = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase

      // Pair bytes into words; a marker pads a dangling high byte with 0xFF.
      if (app) begin
         if (!half_valid) begin
            hi_byte_d    = app_data;
            half_valid_d = 1'b1;
         end else begin
            out_bits_d   = {hi_byte, app_data};
            ena_out_d    = 1'b1;
            out_padded_d = 1'b0;
            half_valid_d = 1'b0;
         end
      end else if (flush && half_valid) begin
         out_bits_d   = {hi_byte, FF_BYTE};
         ena_out_d    = 1'b1;
         out_padded_d = 1'b1;
         half_valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_jpeg_unstuff.sv
// Bench for jpeg_unstuff: directed scenarios, then a random byte stream checked
// against a queue-based model of the unstuffing rules.
module tb_jpeg_unstuff;

   localparam int unsigned CNT_W    = 4;
   localparam int          SAT      = (1 << CNT_W) - 1;
   localparam int          N_RAND   = 300;
   localparam int          WAIT_MAX = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       in_byte;
   logic             ena_in;
   logic             rdy_out;
   logic [15:0]      out_bits;
   logic             ena_out;
   logic             rdy_in;
   logic             out_padded;
   logic [7:0]       marker;
   logic             marker_valid;
   logic             marker_ack;
   logic [CNT_W-1:0] stuff_count;

   jpeg_unstuff #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_byte      (in_byte),
      .ena_in       (ena_in),
      .rdy_out      (rdy_out),
      .out_bits     (out_bits),
      .ena_out      (ena_out),
      .rdy_in       (rdy_in),
      .out_padded   (out_padded),
      .marker       (marker),
      .marker_valid (marker_valid),
      .marker_ack   (marker_ack),
      .stuff_count  (stuff_count)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          rnd_mode = 1'b0;
   logic [16:0] got_q[$];
   logic [16:0] exp_q[$];
   logic [7:0]  pend_q[$];
   bit          prev_ff;
   int          exp_stuff;
   logic [7:0]  exp_marker;

   // Words leaving the block: {out_padded, out_bits}, sampled mid-cycle.
   always @(negedge clk) begin
      if (ena_out && rdy_in) got_q.push_back({out_padded, out_bits});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_mode) rdy_in = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [7:0] b);
      int waited;
      bit ok;
      waited  = 0;
      in_byte = b;
      ena_in  = 1'b1;
      forever begin
         @(negedge clk);
         ok = rdy_out;
         tick();
         if (ok) break;
         waited++;
         if (waited >= WAIT_MAX) begin
            n_cmp++;
            n_fail++;
            $error("FAIL send_timeout: byte %0h not accepted, observed rdy_out=0 expected 1", b);
            break;
         end
      end
      ena_in = 1'b0;
   endtask

   task automatic pulse_ack();
      marker_ack = 1'b1;
      @(posedge clk);
      #1;
      marker_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      ena_in     = 1'b0;
      marker_ack = 1'b0;
      rdy_in     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   function automatic void model_reset();
      prev_ff   = 1'b0;
      exp_stuff = 0;
      pend_q.delete();
      exp_q.delete();
   endfunction

   function automatic void push_data(input logic [7:0] d);
      pend_q.push_back(d);
      if (pend_q.size() == 2) begin
         exp_q.push_back({1'b0, pend_q[0], pend_q[1]});
         pend_q.delete();
      end
   endfunction

   // Returns 1 when the byte completes a marker.
   function automatic bit model_byte(input logic [7:0] b);
      bit hit;
      hit = 1'b0;
      if (!prev_ff) begin
         if (b == 8'hFF) prev_ff = 1'b1;
         else            push_data(b);
      end else if (b == 8'h00) begin
         push_data(8'hFF);
         if (exp_stuff < SAT) exp_stuff++;
         prev_ff = 1'b0;
      end else if (b != 8'hFF) begin
         if (pend_q.size() == 1) begin
            exp_q.push_back({1'b1, pend_q[0], 8'hFF});
            pend_q.delete();
         end
         exp_marker = b;
         prev_ff    = 1'b0;
         hit        = 1'b1;
      end
      return hit;
   endfunction

   initial begin
      logic [7:0] b;
      logic [7:0] tail [2];
      bit         hit;
      int         r;
      int         n;

      rst        = 1'b0;
      in_byte    = 8'h00;
      ena_in     = 1'b0;
      rdy_in     = 1'b1;
      marker_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ena_out", 32'(ena_out), 0);
      check("rst_out_bits", 32'(out_bits), 0);
      check("rst_out_padded", 32'(out_padded), 0);
      check("rst_marker", 32'(marker), 0);
      check("rst_marker_valid", 32'(marker_valid), 0);
      check("rst_stuff_count", 32'(stuff_count), 0);
      check("rst_rdy_out", 32'(rdy_out), 1);
      rst = 1'b1;

      // plain data packing
      send(8'h12);
      send(8'h34);
      check("t1_ena_out", 32'(ena_out), 1);
      check("t1_word0", 32'(out_bits), 32'h1234);
      send(8'h56);
      send(8'h78);
      check("t1_word1", 32'(out_bits), 32'h5678);
      check("t1_padded", 32'(out_padded), 0);
      check("t1_stuff", 32'(stuff_count), 0);

      // stuffed zero
      do_reset();
      send(8'h12);
      send(8'hFF);
      send(8'h00);
      check("t2_word", 32'(out_bits), 32'h12FF);
      check("t2_ena_out", 32'(ena_out), 1);
      send(8'h34);
      check("t2_half_valid", 32'(dut.half_valid), 1);
      check("t2_hi_byte", 32'(dut.hi_byte), 32'h34);
      check("t2_stuff", 32'(stuff_count), 1);

      // marker with padded flush
      do_reset();
      send(8'hAB);
      send(8'hFF);
      send(8'hD9);
      check("t3_word", 32'(out_bits), 32'hABFF);
      check("t3_padded", 32'(out_padded), 1);
      check("t3_marker", 32'(marker), 32'hD9);
      check("t3_marker_valid", 32'(marker_valid), 1);
      check("t3_rdy_out_halt", 32'(rdy_out), 0);
      pulse_ack();
      check("t3_marker_valid_ack", 32'(marker_valid), 0);
      check("t3_rdy_out_ack", 32'(rdy_out), 1);
      check("t3_marker_kept", 32'(marker), 32'hD9);

      // fill bytes
      do_reset();
      send(8'hFF);
      send(8'hFF);
      send(8'hFF);
      send(8'h00);
      send(8'h42);
      check("t4_word", 32'(out_bits), 32'hFF42);
      check("t4_padded", 32'(out_padded), 0);
      check("t4_stuff", 32'(stuff_count), 1);

      // backpressure and same-cycle drain/load
      do_reset();
      rdy_in = 1'b0;
      got_q.delete();
      send(8'h11);
      send(8'h22);
      send(8'h33);
      check("t5_word_held", 32'(out_bits), 32'h1122);
      check("t5_rdy_out_full", 32'(rdy_out), 0);
      rdy_in = 1'b1;
      send(8'h44);
      check("t5_word_next", 32'(out_bits), 32'h3344);
      check("t5_ena_out", 32'(ena_out), 1);
      @(posedge clk);
      #1;
      check("t5_drain_count", 32'(got_q.size()), 2);
      if (got_q.size() == 2) begin
         check("t5_drain0", 32'(got_q[0]), 32'h01122);
         check("t5_drain1", 32'(got_q[1]), 32'h03344);
      end

      // asynchronous reset from SAW_FF
      do_reset();
      send(8'h55);
      send(8'hFF);
      send(8'h00);
      check("t6_pre_stuff", 32'(stuff_count), 1);
      send(8'hFF);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_ena_out", 32'(ena_out), 0);
      check("t6_async_out_bits", 32'(out_bits), 0);
      check("t6_async_half", 32'(dut.half_valid), 0);
      check("t6_async_stuff", 32'(stuff_count), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(8'h00);
      send(8'h66);
      check("t6_word", 32'(out_bits), 32'h0066);
      check("t6_stuff", 32'(stuff_count), 0);

      // counter saturation
      do_reset();
      for (int k = 0; k < 17; k++) begin
         send(8'hFF);
         send(8'h00);
         if (k == 13) check("t7_stuff_14", 32'(stuff_count), 14);
      end
      check("t7_stuff_sat", 32'(stuff_count), SAT);

      // random stream against the model
      do_reset();
      model_reset();
      got_q.delete();
      rnd_mode = 1'b1;
      for (int i = 0; i < N_RAND + 2; i++) begin
         if (i < N_RAND) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      b = 8'hFF;
            else if (r < 5) b = 8'h00;
            else            b = 8'($urandom_range(0, 255));
         end else begin
            tail[0] = 8'hFF;
            tail[1] = 8'hD9;
            b = tail[i - N_RAND];
         end
         hit = model_byte(b);
         send(b);
         if (hit) begin
            check("rnd_marker", 32'(marker), 32'(exp_marker));
            check("rnd_marker_valid", 32'(marker_valid), 1);
            pulse_ack();
         end
      end
      rnd_mode = 1'b0;
      rdy_in   = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rnd_word_count", 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("rnd_word", 32'(got_q[i]), 32'(exp_q[i]));
      check("rnd_stuff", 32'(stuff_count), 32'(exp_stuff));
      check("rnd_half_empty", 32'(dut.half_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_unstuff.md
Name: jpeg_unstuff

Overview:
Decoder-side counterpart of the byte-stuffing stage in jpeg_pipeline. It takes the entropy-coded JPEG byte stream, removes every stuffed 0x00 that follows 0xFF, and discards fill 0xFF bytes. It detects markers (0xFF followed by 0x01..0xFE) and repacks the unstuffed data MSB-first into 16-bit words for the downstream Huffman decoder. On a marker it pads and flushes any partial word, reports the marker code, and halts until acknowledged.

Parameters:
CNT_W, 16, width of the saturating stuffed-byte counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low.
in_byte  input  8  compressed stream byte.
ena_in  input  1  in_byte is valid.
rdy_out  output  1  block accepts in_byte this cycle; a transfer occurs when ena_in && rdy_out.
out_bits  output  16  unstuffed data word; the first byte received is in [15:8].
ena_out  output  1  out_bits is valid.
rdy_in  input  1  downstream accepts out_bits; a transfer occurs when ena_out && rdy_in.
out_padded  output  1  qualifies out_bits; high when [7:0] is 0xFF padding from a marker flush.
marker  output  8  last detected marker code.
marker_valid  output  1  a marker has been detected; block is halted.
marker_ack  input  1  one-cycle pulse that releases the halt.
stuff_count  output  CNT_W  number of stuffed 0x00 bytes removed; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): state=NORMAL, half_valid=0, ena_out=0, out_bits=0, out_padded=0, marker=0, marker_valid=0, stuff_count=0. Reset overrides any operation in progress, including SAW_FF and MARKER.
- Storage:
  - Output register: out_bits, ena_out, out_padded.
  - Half register: hi_byte plus half_valid.
- Output register clears when it drains (ena_out && rdy_in) and no new word loads in the same cycle.
- rdy_out = (state != MARKER) && (!half_valid || !ena_out || rdy_in). This is combinational and has no dependence on ena_in.
- Appending a data byte D:
  - If half_valid=0: hi_byte <= D, half_valid <= 1.
  - Otherwise: out_bits <= {hi_byte, D}, ena_out <= 1, out_padded <= 0, half_valid <= 0.
  - Latency is 1 cycle from acceptance of the completing byte to ena_out.
  - A simultaneous drain and load is legal: the new word replaces the old one with no bubble.
- State machine (transitions only on an accepted byte, unless noted):
  - NORMAL, byte != 0xFF: append byte; stay in NORMAL.
  - NORMAL, byte == 0xFF: nothing appended; go to SAW_FF.
  - SAW_FF, byte == 0x00: append 0xFF; stuff_count++ (saturating); go to NORMAL.
  - SAW_FF, byte == 0xFF: fill byte, discarded; stay in SAW_FF.
  - SAW_FF, any other byte: marker <= byte, marker_valid <= 1.
    - If half_valid: out_bits <= {hi_byte, 0xFF}, ena_out <= 1, out_padded <= 1, half_valid <= 0.
    - Go to MARKER.
  - MARKER: rdy_out=0; the output register keeps draining normally.
  - MARKER exit: marker_ack=1 → marker_valid <= 0, state <= NORMAL. The marker value is retained.
  - marker_ack outside MARKER is ignored.
- Stream ending in SAW_FF (0xFF never followed): nothing is emitted; the block waits indefinitely.
- stuff_count holds at 2^CNT_W-1 once it is reached.
- With ena_in=0, no state, half, or counter change occurs.

Test Plan:
1. Bytes 12,34,56,78 back-to-back, rdy_in=1 → out_bits 0x1234 one cycle after 0x34 is accepted, then 0x5678; out_padded=0; stuff_count=0.
2. Bytes 12,FF,00,34 → single word 0x12FF; half_valid=1 with hi_byte=0x34; stuff_count=1.
3. Bytes AB,FF,D9 → word 0xABFF with out_padded=1; marker=0xD9, marker_valid=1, rdy_out=0; after a marker_ack pulse, marker_valid=0 and rdy_out=1.
4. Bytes FF,FF,FF,00,42 → fill bytes dropped; word 0xFF42; stuff_count=1.
5. rdy_in=0, bytes 11,22,33 → 0x1122 held and 33 accepted; rdy_out=0 while ena_out=1 and half_valid=1. Raise rdy_in, send 44 → 0x1122 consumed, then 0x3344.
6. Bytes 55,FF; drive rst=0 mid-cycle (asynchronous), release it, then send 00,66 → outputs clear immediately; next word is 0x0066; stuff_count=0.
